// File: rtl/transpose_buffer_db.sv
// transpose_buffer_db
//   Double-buffered tile transpose. Row fetches of FETCH_WIDTH words are
//   compacted (valid lanes packed low, order kept, rest zeroed) and written
//   into the current write bank. When NUM_ROWS rows have landed the bank is
//   marked full. The read side then emits it column by column, while the
//   other bank fills.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of pointers and bank state
//   in_valid/ready  fetch handshake; in_data lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   in_lane_valid   per-lane valid mask for compaction
//   cfg_num_cols    columns to emit, latched on a tile's first row (0 or >FETCH_WIDTH -> FETCH_WIDTH)
//   out_valid/ready column handshake
//   out_col         word r = row r of the current column
//   out_col_idx     current column index
//   out_last        current column is the tile's last
//   num_full        number of full banks (0..2)
module transpose_buffer_db #(
  parameter int WORD_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_ROWS    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FETCH_WIDTH*WORD_WIDTH-1:0] in_data,
  input  logic [FETCH_WIDTH-1:0]            in_lane_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]  cfg_num_cols,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_ROWS*WORD_WIDTH-1:0]    out_col,
  output logic [$clog2(FETCH_WIDTH)-1:0]    out_col_idx,
  output logic                              out_last,
  output logic [1:0]                        num_full
);

  localparam int CW = $clog2(FETCH_WIDTH+1);
  localparam int IW = $clog2(FETCH_WIDTH);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int DW = FETCH_WIDTH*WORD_WIDTH;

  logic [DW-1:0] mem [2][NUM_ROWS];

  logic          wbank, rbank;
  logic [RW-1:0] row;
  logic [IW-1:0] col;
  logic [1:0]    full;
  logic [CW-1:0] ncols [2];

  logic [DW-1:0] packed_row;
  logic [CW-1:0] cfg_clamped;
  logic [CW-1:0] last_idx;
  logic          col_last;
  logic          wr_fire, rd_fire;

  // Lane compaction: each valid lane lands at the next free low slot.
  always_comb begin
    int unsigned pos;
    packed_row = '0;
    pos = 0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (in_lane_valid[i]) begin
        packed_row[pos*WORD_WIDTH +: WORD_WIDTH] = in_data[i*WORD_WIDTH +: WORD_WIDTH];
        pos++;
      end
    end
  end

  always_comb begin
    cfg_clamped = cfg_num_cols;
    if (cfg_num_cols == '0 || cfg_num_cols > CW'(FETCH_WIDTH))
      cfg_clamped = CW'(FETCH_WIDTH);
  end

  assign in_ready  = !full[wbank] && !flush;
  assign out_valid = full[rbank] && !flush;
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  assign last_idx  = ncols[rbank] - CW'(1);
  assign col_last  = (CW'(col) == last_idx);
  assign num_full  = 2'(full[0]) + 2'(full[1]);

  always_comb begin
    out_col     = '0;
    out_col_idx = '0;
    out_last    = 1'b0;
    if (out_valid) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++)
        out_col[r*WORD_WIDTH +: WORD_WIDTH] = mem[rbank][r][col*WORD_WIDTH +: WORD_WIDTH];
      out_col_idx = col;
      out_last    = col_last;
    end
  end

  // Tile storage carries no reset; contents are only visible once a bank is full.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wbank][row] <= packed_row;
  end

  // Write completion and read completion always hit different banks
  // (writes need a non-full bank, reads a full one), so both full-flag
  // updates may land in the same cycle without conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      row      <= '0;
      col      <= '0;
      full     <= '0;
      ncols[0] <= CW'(FETCH_WIDTH);
      ncols[1] <= CW'(FETCH_WIDTH);
    end else if (flush) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      row   <= '0;
      col   <= '0;
      full  <= '0;
    end else begin
      if (wr_fire) begin
        if (row == '0)
          ncols[wbank] <= cfg_clamped;
        if (row == RW'(NUM_ROWS-1)) begin
          row         <= '0;
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
        end else begin
          row <= row + RW'(1);
        end
      end
      if (rd_fire) begin
        if (col_last) begin
          col         <= '0;
          full[rbank] <= 1'b0;
          rbank       <= !rbank;
        end else begin
          col <= col + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_buffer_db.sv
// tb_transpose_buffer_db
//   Directed bench for transpose_buffer_db with default parameters
//   (16-bit words, 4 lanes, 4 rows). Expected columns come from the tile
//   pattern: row r, lane c of a tile with base B holds B + 4r + c.
module tb_transpose_buffer_db;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_lane_valid;
  logic [2:0]  cfg_num_cols;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_col;
  logic [1:0]  out_col_idx;
  logic        out_last;
  logic [1:0]  num_full;

  int checks = 0;
  int errors = 0;

  transpose_buffer_db #(
    .WORD_WIDTH (16),
    .FETCH_WIDTH(4),
    .NUM_ROWS   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_lane_valid(in_lane_valid),
    .cfg_num_cols (cfg_num_cols),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_col      (out_col),
    .out_col_idx  (out_col_idx),
    .out_last     (out_last),
    .num_full     (num_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] row_data(input logic [15:0] base, input int r);
    return {base + 16'(4*r+3), base + 16'(4*r+2), base + 16'(4*r+1), base + 16'(4*r)};
  endfunction

  function automatic logic [63:0] exp_col(input logic [15:0] base, input int c);
    return {base + 16'(12+c), base + 16'(8+c), base + 16'(4+c), base + 16'(c)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [3:0] m, input logic [2:0] c);
    int n;
    in_valid      = 1'b1;
    in_data       = d;
    in_lane_valid = m;
    cfg_num_cols  = c;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("push_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_tile(input logic [15:0] base, input logic [2:0] c);
    for (int r = 0; r < 4; r++)
      push(row_data(base, r), 4'hF, c);
  endtask

  task automatic pop(input string tag, input logic [63:0] ecol, input int eidx, input bit elast);
    int n;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_col"},   out_col, ecol);
    chk({tag, "_idx"},   64'(out_col_idx), 64'(eidx));
    chk({tag, "_last"},  64'(out_last), 64'(elast));
    step();
    out_ready = 1'b0;
  endtask

  task automatic pop_tile(input string tag, input logic [15:0] base);
    for (int c = 0; c < 4; c++)
      pop(tag, exp_col(base, c), c, c == 3);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_num_full"}, 64'(num_full), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int rows_sent;
    int cols_got;
    logic [15:0] sb;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_lane_valid = '0; cfg_num_cols = '0;

    // Reset state
    #3;
    chk_idle("rst");
    chk("rst_out_col", out_col, 64'd0);
    chk("rst_out_idx", 64'(out_col_idx), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    #9 rst_n = 1'b1;
    step();

    // Basic tile: 1-cycle latency and transposed columns
    for (int r = 0; r < 3; r++) push(row_data(16'h0, r), 4'hF, 3'd4);
    chk("t1_no_early_valid", 64'(out_valid), 64'd0);
    push(row_data(16'h0, 3), 4'hF, 3'd4);
    chk("t1_valid_next", 64'(out_valid), 64'd1);
    chk("t1_num_full", 64'(num_full), 64'd1);
    chk("t1_col0", out_col, {16'd12, 16'd8, 16'd4, 16'd0});
    pop_tile("t1", 16'h0);
    chk_idle("t1_end");

    // Compaction: 1010 -> {0,0,D,B}; 0000 -> zero row; 1001 -> {0,0,w3,w0}
    push({16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 4'b1010, 3'd4);
    push(row_data(16'h50, 0), 4'b0000, 3'd4);
    push({16'h23, 16'h22, 16'h21, 16'h20}, 4'b1001, 3'd4);
    push({16'h33, 16'h32, 16'h31, 16'h30}, 4'hF, 3'd4);
    pop("cmp0", {16'h30, 16'h20, 16'h0, 16'hBBBB}, 0, 0);
    pop("cmp1", {16'h31, 16'h23, 16'h0, 16'hDDDD}, 1, 0);
    pop("cmp2", {16'h32, 16'h00, 16'h0, 16'h0000}, 2, 0);
    pop("cmp3", {16'h33, 16'h00, 16'h0, 16'h0000}, 3, 1);

    // Both banks full: back-pressure until bank drains its last column
    push_tile(16'h100, 3'd4);
    push_tile(16'h200, 3'd4);
    chk("bp_num_full2", 64'(num_full), 64'd2);
    chk("bp_in_ready0", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_data = row_data(16'h300, 0); in_lane_valid = 4'hF; cfg_num_cols = 3'd4;
    step();
    chk("bp_held_num_full", 64'(num_full), 64'd2);
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'b1;
      #1;
      chk("bp_col", out_col, exp_col(16'h100, c));
      chk("bp_idx", 64'(out_col_idx), 64'(c));
      chk("bp_last", 64'(out_last), 64'(c == 3));
      step();
      chk("bp_in_ready", 64'(in_ready), 64'(c == 3));
    end
    out_ready = 1'b0;
    chk("bp_num_full1", 64'(num_full), 64'd1);
    step();
    in_valid = 1'b0;
    for (int r = 1; r < 4; r++) push(row_data(16'h300, r), 4'hF, 3'd4);
    chk("bp_refill_full2", 64'(num_full), 64'd2);
    pop_tile("bp_t2", 16'h200);
    pop_tile("bp_t3", 16'h300);
    chk_idle("bp_end");

    // Column count: 2 for tile A, 0 (clamped to 4) for tile B; only row 0 latches
    push(row_data(16'h400, 0), 4'hF, 3'd2);
    for (int r = 1; r < 4; r++) push(row_data(16'h400, r), 4'hF, 3'd3);
    push(row_data(16'h500, 0), 4'hF, 3'd0);
    for (int r = 1; r < 4; r++) push(row_data(16'h500, r), 4'hF, 3'd2);
    pop("nc2_c0", exp_col(16'h400, 0), 0, 0);
    pop("nc2_c1", exp_col(16'h400, 1), 1, 1);
    pop_tile("nc0", 16'h500);
    chk_idle("nc_end");

    // Streaming with out_ready toggling; stalled column must be the expected one
    rows_sent = 0;
    cols_got  = 0;
    for (int k = 0; k < 200 && (rows_sent < 8 || cols_got < 8); k++) begin
      sb            = (rows_sent < 4) ? 16'h600 : 16'h700;
      in_valid      = (rows_sent < 8);
      in_data       = row_data(sb, rows_sent % 4);
      in_lane_valid = 4'hF;
      cfg_num_cols  = (rows_sent < 4) ? 3'd7 : 3'd4;
      out_ready     = (k % 2 == 0);
      #1;
      if (out_valid && cols_got < 8) begin
        sb = (cols_got < 4) ? 16'h600 : 16'h700;
        chk("st_col", out_col, exp_col(sb, cols_got % 4));
        chk("st_idx", 64'(out_col_idx), 64'(cols_got % 4));
        chk("st_last", 64'(out_last), 64'(cols_got % 4 == 3));
        if (out_ready) cols_got++;
      end
      if (in_valid && in_ready) rows_sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("st_rows_sent", 64'(rows_sent), 64'd8);
    chk("st_cols_got", 64'(cols_got), 64'd8);
    #1;
    chk_idle("st_end");

    // Flush mid-fill
    push(row_data(16'h800, 0), 4'hF, 3'd4);
    push(row_data(16'h800, 1), 4'hF, 3'd4);
    flush = 1'b1; in_valid = 1'b1; in_data = row_data(16'h800, 2);
    #1;
    chk("fl_fill_in_ready", 64'(in_ready), 64'd0);
    chk("fl_fill_out_valid", 64'(out_valid), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk_idle("fl_fill");
    push_tile(16'h900, 3'd4);
    pop_tile("fl_fill_t", 16'h900);

    // Flush mid-drain
    push_tile(16'hA00, 3'd4);
    pop("fl_drain_c0", exp_col(16'hA00, 0), 0, 0);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_drain_out_valid", 64'(out_valid), 64'd0);
    chk("fl_drain_out_col", out_col, 64'd0);
    step();
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk_idle("fl_drain");
    push_tile(16'hB00, 3'd4);
    pop_tile("fl_drain_t", 16'hB00);

    // Asynchronous reset mid-fill
    push(row_data(16'hC00, 0), 4'hF, 3'd4);
    push(row_data(16'hC00, 1), 4'hF, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rs_fill");
    #3 rst_n = 1'b1;
    step();
    push_tile(16'hD00, 3'd4);
    pop_tile("rs_fill_t", 16'hD00);

    // Asynchronous reset mid-drain
    push_tile(16'hE00, 3'd4);
    pop("rs_drain_c0", exp_col(16'hE00, 0), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rs_drain");
    #3 rst_n = 1'b1;
    step();
    push_tile(16'hF00, 3'd4);
    pop_tile("rs_drain_t", 16'hF00);
    chk_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
